// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial shift-register link.
// Contents:
//   S_HOLD/S_RIGHT/S_LEFT/S_LOAD  2-bit link mode codes (transmitter uses the same set)
//   rx_state_t                    receiver FSM state
//   mode_ok()                     true for the two modes that carry serial data
package serial_link_pkg;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;  // LSB first
    localparam logic [1:0] S_LEFT  = 2'b10;  // MSB first
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    function automatic logic mode_ok(input logic [1:0] s);
        return (s == S_RIGHT) || (s == S_LEFT);
    endfunction

endpackage

// File: rtl/rx_shift_core.sv
// W-bit receive shift register.
// Ports:
//   CLK   rising-edge clock
//   clr   start from an all-zero register this cycle (combines with en)
//   en    shift sdi in this cycle
//   dir   0 = right shift (sdi enters at the MSB end), 1 = left shift (sdi enters at bit 0)
//   sdi   serial data bit
//   word  value the register takes at the coming edge; equals the stored
//         value whenever clr=0 and en=0
module rx_shift_core #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         clr,
    input  logic         en,
    input  logic         dir,
    input  logic         sdi,
    output logic [W-1:0] word
);
    import serial_link_pkg::*;

    logic [W-1:0] sh;
    logic [W-1:0] base;
    logic [W-1:0] nxt;

    // clr together with en gives a fresh word whose only bit is sdi, so a
    // restart never carries bits from an abandoned word.
    always_comb begin
        base = clr ? '0 : sh;
        nxt  = base;
        if (en) begin
            if (dir) nxt = {base[W-2:0], sdi};
            else     nxt = {sdi, base[W-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        sh <= nxt;
    end

    // Exposing the next value lets the owner capture a completed word on the
    // same edge that shifts its last bit in.
    assign word = nxt;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a one-word holding buffer.
// Ports:
//   CLK    rising-edge clock
//   CLRN   synchronous active-low reset
//   S      link mode, sampled on the first bit of a word (01 right/LSB first, 10 left/MSB first)
//   SDI    serial data bit, qualified by SEN
//   SEN    bit strobe
//   SOF    start of word (with SEN)
//   READY  consumer takes Q this cycle
//   OCLR   clears OVR and FERR (a same-cycle set wins)
//   Q      received word, stable while VALID=1
//   VALID  Q holds an unconsumed word
//   OVR    sticky overrun flag
//   FERR   sticky framing-error flag
// Handshake: a word transfers on every edge where VALID=1 and READY=1;
// VALID/Q only change at edges and READY has no effect while VALID=0.
module serial_word_rx #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         CLRN,
    input  logic [1:0]   S,
    input  logic         SDI,
    input  logic         SEN,
    input  logic         SOF,
    input  logic         READY,
    input  logic         OCLR,
    output logic [W-1:0] Q,
    output logic         VALID,
    output logic         OVR,
    output logic         FERR
);
    import serial_link_pkg::*;

    localparam int CW = $clog2(W + 1);

    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mode_left, mode_left_nxt;
    logic          sh_clr, sh_en, sh_dir;
    logic          complete;
    logic          ferr_set;
    logic          ovr_set;
    logic          s_ok;
    logic [W-1:0]  word;

    logic [W-1:0]  q_r;
    logic          valid_r, ovr_r, ferr_r;

    assign s_ok = mode_ok(S);

    // State register
    always_ff @(posedge CLK) begin
        if (!CLRN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state, bit counter and shift-register control
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mode_left_nxt = mode_left;
        sh_clr        = 1'b0;
        sh_en         = 1'b0;
        sh_dir        = mode_left;
        complete      = 1'b0;
        ferr_set      = 1'b0;
        if (SEN) begin
            if (SOF) begin
                // A start while a word is in progress abandons it; a start
                // with a non-data mode is dropped. Both are framing errors.
                ferr_set = (state == ST_SHIFT) || !s_ok;
                if (s_ok) begin
                    state_nxt     = ST_SHIFT;
                    cnt_nxt       = CW'(1);
                    mode_left_nxt = (S == S_LEFT);
                    sh_clr        = 1'b1;
                    sh_en         = 1'b1;
                    sh_dir        = (S == S_LEFT);
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end else if (state == ST_SHIFT) begin
                sh_en = 1'b1;
                if (cnt == CW'(W - 1)) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else begin
                // Data bit with no word open
                ferr_set = 1'b1;
            end
        end
    end

    assign ovr_set = complete && valid_r && !READY;

    rx_shift_core #(.W(W)) u_core (
        .CLK  (CLK),
        .clr  (sh_clr || !CLRN),
        .en   (sh_en && CLRN),
        .dir  (sh_dir),
        .sdi  (SDI),
        .word (word)
    );

    // Counter, latched mode, holding buffer and flags
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            cnt       <= '0;
            mode_left <= 1'b0;
            q_r       <= '0;
            valid_r   <= 1'b0;
            ovr_r     <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            mode_left <= mode_left_nxt;
            // A completing word may replace a buffered one only if the
            // consumer takes the old word on the same edge.
            if (complete && (!valid_r || READY)) begin
                q_r     <= word;
                valid_r <= 1'b1;
            end else if (valid_r && READY) begin
                valid_r <= 1'b0;
            end
            ovr_r  <= ovr_set  || (ovr_r  && !OCLR);
            ferr_r <= ferr_set || (ferr_r && !OCLR);
        end
    end

    assign Q     = q_r;
    assign VALID = valid_r;
    assign OVR   = ovr_r;
    assign FERR  = ferr_r;

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;
    import serial_link_pkg::*;

    localparam int W = 4;

    logic         CLK;
    logic         CLRN;
    logic [1:0]   S;
    logic         SDI;
    logic         SEN;
    logic         SOF;
    logic         READY;
    logic         OCLR;
    logic [W-1:0] Q;
    logic         VALID;
    logic         OVR;
    logic         FERR;

    int checks = 0;
    int errors = 0;

    serial_word_rx #(.W(W)) dut (
        .CLK   (CLK),
        .CLRN  (CLRN),
        .S     (S),
        .SDI   (SDI),
        .SEN   (SEN),
        .SOF   (SOF),
        .READY (READY),
        .OCLR  (OCLR),
        .Q     (Q),
        .VALID (VALID),
        .OVR   (OVR),
        .FERR  (FERR)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    // Receiver behaviour expressed as "bits collected so far" plus a one-word buffer.
    logic         m_busy;
    logic         m_left;
    logic         m_bits[$];
    logic [W-1:0] m_q;
    logic         m_valid;
    logic         m_ovr;
    logic         m_ferr;
    logic [W-1:0] exp_q[$];   // words loaded into Q and not yet handed over

    function automatic logic [W-1:0] assemble();
        int unsigned v;
        v = 0;
        for (int i = 0; i < m_bits.size(); i++) begin
            if (m_left) v = v * 2 + int'(m_bits[i]);
            else        v = v + (int'(m_bits[i]) << i);
        end
        return W'(v);
    endfunction

    task automatic model_update(input logic sen, input logic sof, input logic [1:0] s,
                                input logic sdi, input logic rdy, input logic oclr);
        logic         consumed, load, ovr_set, ferr_set;
        logic [W-1:0] w;
        if (!CLRN) begin
            m_busy  = 1'b0;
            m_left  = 1'b0;
            m_bits.delete();
            m_q     = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            exp_q.delete();
            return;
        end
        consumed = m_valid && rdy;
        load     = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        w        = '0;
        if (sen) begin
            if (sof) begin
                if (m_busy) ferr_set = 1'b1;
                m_bits.delete();
                if (s == S_RIGHT || s == S_LEFT) begin
                    m_busy = 1'b1;
                    m_left = (s == S_LEFT);
                    m_bits.push_back(sdi);
                end else begin
                    m_busy   = 1'b0;
                    ferr_set = 1'b1;
                end
            end else if (!m_busy) begin
                ferr_set = 1'b1;
            end else begin
                m_bits.push_back(sdi);
                if (m_bits.size() == W) begin
                    w      = assemble();
                    m_busy = 1'b0;
                    m_bits.delete();
                    if (!m_valid || rdy) load = 1'b1;
                    else                 ovr_set = 1'b1;
                end
            end
        end
        if (load) begin
            m_q     = w;
            m_valid = 1'b1;
            exp_q.push_back(w);
        end else if (consumed) begin
            m_valid = 1'b0;
        end
        m_ovr  = ovr_set  || (m_ovr  && !oclr);
        m_ferr = ferr_set || (m_ferr && !oclr);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive inputs, score any hand-over, advance model and compare.
    task automatic step(input logic sen, input logic sof, input logic [1:0] s,
                        input logic sdi, input logic rdy, input logic oclr);
        SEN = sen; SOF = sof; S = s; SDI = sdi; READY = rdy; OCLR = oclr;
        #1;
        if (CLRN && m_valid && rdy) begin
            if (exp_q.size() == 0) check("drain_nothing_expected", 16'd1, 16'd0);
            else                   check("drain_word", 16'(Q), 16'(exp_q.pop_front()));
        end
        @(posedge CLK);
        model_update(sen, sof, s, sdi, rdy, oclr);
        #1;
        check("q",     16'(Q),     16'(m_q));
        check("valid", 16'(VALID), 16'(m_valid));
        check("ovr",   16'(OVR),   16'(m_ovr));
        check("ferr",  16'(FERR),  16'(m_ferr));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, S_HOLD, 1'b0, rdy, 1'b0);
    endtask

    task automatic reset_dut(input int n);
        CLRN = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, S_HOLD, 1'b0, 1'b0, 1'b0);
            check("rst_outputs", {11'd0, VALID, OVR, FERR, Q[1:0] | Q[3:2]}, 16'd0);
        end
        CLRN = 1'b1;
    endtask

    // Send one whole word in the given mode, `gap` idle cycles between bits.
    task automatic send_word(input logic [1:0] s, input logic [W-1:0] word, input int gap,
                             input logic rdy, input logic last_rdy);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = (s == S_LEFT) ? word[W-1-i] : word[i];
            step(1'b1, (i == 0), (i == 0) ? s : S_HOLD, b, (i == W - 1) ? last_rdy : rdy, 1'b0);
            if (i != W - 1) idle(gap, rdy);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic       sen, sof, sdi, rdy, oclr;
        logic [1:0] s;
        CLRN = 1'b0; SEN = 1'b0; SOF = 1'b0; S = S_HOLD; SDI = 1'b0; READY = 1'b0; OCLR = 1'b0;
        model_update(1'b0, 1'b0, S_HOLD, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        reset_dut(2);

        // LSB-first word, bits 1,0,1,1
        step(1'b1, 1'b1, S_RIGHT, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, S_HOLD,  1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, S_HOLD,  1'b1, 1'b1, 1'b0);
        check("t1_no_valid_before_last", 16'(VALID), 16'd0);
        step(1'b1, 1'b0, S_HOLD,  1'b1, 1'b1, 1'b0);
        check("t1_q", 16'(Q), 16'h000D);
        check("t1_valid", 16'(VALID), 16'd1);
        idle(1, 1'b1);
        check("t1_valid_one_cycle", 16'(VALID), 16'd0);
        check("t1_q_kept", 16'(Q), 16'h000D);

        // MSB-first word, bits 1,0,1,1 with 2-cycle gaps
        reset_dut(1);
        send_word(S_LEFT, 4'b1011, 2, 1'b0, 1'b0);
        check("t2_q", 16'(Q), 16'h000B);
        check("t2_valid", 16'(VALID), 16'd1);
        check("t2_no_ferr", 16'(FERR), 16'd0);
        idle(1, 1'b1);

        // Overrun: A then 5 with READY low
        reset_dut(1);
        send_word(S_RIGHT, 4'hA, 0, 1'b0, 1'b0);
        send_word(S_LEFT,  4'h5, 0, 1'b0, 1'b0);
        check("t3_q_kept", 16'(Q), 16'h000A);
        check("t3_ovr", 16'(OVR), 16'd1);
        step(1'b0, 1'b0, S_HOLD, 1'b0, 1'b0, 1'b1);
        check("t3_ovr_cleared", 16'(OVR), 16'd0);
        idle(1, 1'b1);

        // Framing: restart mid-word with a new mode
        reset_dut(1);
        step(1'b1, 1'b1, S_RIGHT, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, S_HOLD,  1'b1, 1'b0, 1'b0);
        send_word(S_LEFT, 4'b0001, 0, 1'b0, 1'b0);
        check("t4_ferr", 16'(FERR), 16'd1);
        check("t4_q", 16'(Q), 16'h0001);
        // OCLR in the same cycle as a new framing error: the set wins
        step(1'b1, 1'b0, S_HOLD, 1'b0, 1'b1, 1'b1);
        check("t4_set_wins", 16'(FERR), 16'd1);

        // Completion in the same cycle as draining the previous word
        reset_dut(1);
        send_word(S_RIGHT, 4'h6, 0, 1'b0, 1'b0);
        send_word(S_RIGHT, 4'h9, 0, 1'b0, 1'b1);
        check("t5_q_new", 16'(Q), 16'h0009);
        check("t5_valid", 16'(VALID), 16'd1);
        check("t5_no_ovr", 16'(OVR), 16'd0);
        idle(1, 1'b1);

        // Reset mid-word, then a clean word
        reset_dut(1);
        step(1'b1, 1'b1, S_RIGHT, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, S_HOLD,  1'b1, 1'b0, 1'b0);
        reset_dut(2);
        send_word(S_RIGHT, 4'h3, 0, 1'b1, 1'b1);
        check("t6_q", 16'(Q), 16'h0003);
        check("t6_valid", 16'(VALID), 16'd1);
        check("t6_no_ferr", 16'(FERR), 16'd0);

        // Back-to-back full rate with READY high: no overrun
        for (int k = 0; k < 6; k++) send_word((k % 2) ? S_LEFT : S_RIGHT, W'(k * 3 + 1), 0, 1'b1, 1'b1);
        check("b2b_q", 16'(Q), 16'h0010 & 16'h000F | 16'h0000 | 16'(W'(5 * 3 + 1)));
        check("b2b_no_ovr", 16'(OVR), 16'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            CLRN = ($urandom_range(0, 299) != 0);
            sen  = ($urandom_range(0, 9) < 7);
            sof  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) < 8) s = $urandom_range(0, 1) ? S_RIGHT : S_LEFT;
            else                          s = $urandom_range(0, 1) ? S_HOLD : S_LOAD;
            sdi  = 1'($urandom_range(0, 1));
            rdy  = ($urandom_range(0, 3) != 0);
            oclr = ($urandom_range(0, 19) == 0);
            step(sen, sof, s, sdi, rdy, oclr);
        end
        CLRN = 1'b1;
        idle(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver for the 4-bit universal shift-register datapath. Accepts one bit per qualified clock from a shift-mode transmitter (right shift, LSB first, or left shift, MSB first), reassembles W-bit words, and presents each word on a parallel bus with a VALID/READY handshake and a one-word holding buffer. Sits at the far end of the serial link, feeding a parallel consumer. Overrun and framing errors are reported on sticky flags.

## Interface
- W, default 4: word width in bits; legal range 2..16.
- CLK  in  1  rising-edge clock.
- CLRN  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- S  in  2  link mode, sampled only on the first bit of a word: 01 = right shift (LSB first), 10 = left shift (MSB first), 00/11 = invalid.
- SDI  in  1  serial data bit.
- SEN  in  1  bit strobe; SDI is valid when SEN=1.
- SOF  in  1  start of word; meaningful only when SEN=1.
- READY  in  1  consumer accepts Q this cycle.
- OCLR  in  1  clears OVR and FERR.
- Q  out  W  received word; stable while VALID=1.
- VALID  out  1  Q holds an unconsumed word.
- OVR  out  1  sticky overrun flag.
- FERR  out  1  sticky framing-error flag.

## Operation
- Reset (CLRN=0 at an edge): state IDLE, bit count 0, shift register 0, Q=0, VALID=0, OVR=0, FERR=0. Reset overrides every other input, including a reset that arrives mid-word.
- States are IDLE and SHIFT.
- IDLE:
  - SEN=1, SOF=1 and S=01 or 10: latch the mode, shift in SDI as bit 1, set count=1, go to SHIFT.
  - SEN=1, SOF=1 and S=00 or 11: drop the bit, stay in IDLE, set FERR.
  - SEN=1, SOF=0: drop the bit, set FERR.
- SHIFT:
  - SEN=0: hold all state; gaps of any length are allowed.
  - SEN=1, SOF=0: shift in SDI and increment count.
  - SEN=1, SOF=1: abandon the partial word, set FERR, and restart exactly as in the IDLE start case. This includes changing to the newly sampled S.
- Shift rule:
  - Mode 01: sh <= {SDI, sh[W-1:1]}. The first bit lands in Q[0].
  - Mode 10: sh <= {sh[W-2:0], SDI}. The first bit lands in Q[W-1].
- Word completion happens on the cycle the W-th bit is accepted. That cycle also returns the FSM to IDLE.
  - If VALID=0, or VALID=1 and READY=1 in the same cycle: load Q with the assembled word and set VALID=1.
  - Otherwise: drop the new word, leave Q unchanged, and set OVR.
- Handshake:
  - VALID=1 and READY=1 with no completion in that cycle: clear VALID. Q keeps its last value.
  - READY is ignored while VALID=0.
- OCLR=1 clears OVR and FERR. If an error is raised in the same cycle, the set wins.
- Count width is clog2(W+1). The count never wraps; it resets to 0 on completion.

## Timing
- Latency: the W-th bit accepted at edge n gives VALID=1 and a valid Q after edge n. Q is usable in cycle n+1.
- Back-to-back words: SOF may arrive on the cycle immediately after completion. Sustained throughput is 1 word per W cycles.
- With READY held at 1, there is no overrun at full rate.
- Flags update one edge after the causing event.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package serial_link_pkg holds:
  - Mode constants S_HOLD=2'b00, S_RIGHT=2'b01, S_LEFT=2'b10, S_LOAD=2'b11. The transmitter side uses the same set.
  - The state enum {ST_IDLE, ST_SHIFT}.
- One sub-module, rx_shift_core: a W-bit shift register with inputs clr, en, dir and sdi, and output word. The top level owns the FSM, counter, holding buffer and flags.

## Test plan
- W=4, S=01, SOF on the first bit, bits 1,0,1,1 with READY=1 -> after the 4th edge Q=4'b1101, VALID=1 for one cycle.
- W=4, S=10, bits 1,0,1,1 with 2-cycle SEN gaps between bits -> Q=4'b1011; VALID rises only after the 4th qualified bit.
- READY=0, two full words 4'hA then 4'h5 sent -> Q stays 4'hA, OVR=1; OCLR pulse -> OVR=0.
- S=01, bits 1,1 then SOF with S=10 and bits 0,0,0,1 -> FERR=1, Q=4'b0001.
- Word completes in the same cycle READY=1 drains a prior word -> new Q loaded, VALID stays 1, OVR=0.
- CLRN=0 after 2 of 4 bits, then a full word 4'h3 -> all outputs 0 during reset, no stale bits, Q=4'h3 afterwards.
